// File: rtl/npu_pkg.sv
// npu_pkg: shared row/result widths and arbiter state encoding
// for the conv_engine sharing path.
package npu_pkg;

  localparam int PIXEL_W      = 8;
  localparam int ROW_PIXELS   = 32;
  localparam int ROW_W        = PIXEL_W * ROW_PIXELS;
  localparam int RESULT_W     = 18;
  localparam int RESULT_LEN   = 30;
  localparam int RESULT_BUS_W = RESULT_W * RESULT_LEN;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESPOND
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, one-hot grant plus index.
// Search starts at ptr and wraps at NUM_REQ-1 (any NUM_REQ, not only 2^n).
module rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
      cand = (cand == LAST) ? '0 : cand + 1'b1;
    end
  end

endmodule

// File: rtl/conv_engine_arbiter.sv
// conv_engine_arbiter: round-robin sharing of one conv_engine between
// row producers, with a done watchdog and id-tagged responses.
module conv_engine_arbiter
  import npu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ROW_W-1:0]     req_pixels,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         eng_start,
  output logic [ROW_W-1:0]             eng_pixels,
  input  logic                         eng_done,
  input  logic [RESULT_BUS_W-1:0]      eng_result,
  output logic                         resp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   resp_id,
  output logic                         resp_err,
  output logic [RESULT_BUS_W-1:0]      resp_data,
  output logic                         busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);
  localparam logic [TW-1:0] T_END = TW'(TIMEOUT - 1);

  arb_state_t              state_q, state_d;
  logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]           grant_q, grant_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [ROW_W-1:0]        eng_pixels_q, eng_pixels_d;
  logic                    eng_start_q, eng_start_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [IW-1:0]           resp_id_q, resp_id_d;
  logic                    resp_err_q, resp_err_d;
  logic [RESULT_BUS_W-1:0] resp_data_q, resp_data_d;

  logic [NUM_REQ-1:0]      pick_gnt;
  logic [IW-1:0]           pick_idx;
  logic                    xfer;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign req_ready  = (state_q == IDLE) ? pick_gnt : '0;
  assign xfer       = |(req_valid & req_ready);

  assign eng_start  = eng_start_q;
  assign eng_pixels = eng_pixels_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_data_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    timer_d      = timer_q;
    eng_pixels_d = eng_pixels_q;
    eng_start_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_err_d   = resp_err_q;
    resp_data_d  = resp_data_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          eng_pixels_d = req_pixels[pick_idx * ROW_W +: ROW_W];
          grant_d      = pick_idx;
          eng_start_d  = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // done outranks a watchdog expiry in the same cycle
        if (eng_done) begin
          resp_data_d  = eng_result;
          resp_err_d   = 1'b0;
          resp_id_d    = grant_q;
          resp_valid_d = 1'b1;
          state_d      = RESPOND;
        end else if (timer_q == T_END) begin
          resp_data_d  = '0;
          resp_err_d   = 1'b1;
          resp_id_d    = grant_q;
          resp_valid_d = 1'b1;
          state_d      = RESPOND;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESPOND: begin
        rr_ptr_d = (grant_q == LAST) ? '0 : grant_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      timer_q      <= '0;
      eng_pixels_q <= '0;
      eng_start_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      timer_q      <= timer_d;
      eng_pixels_q <= eng_pixels_d;
      eng_start_q  <= eng_start_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
    end
  end

endmodule

// File: doc/conv_engine_arbiter.md
Name: conv_engine_arbiter

Overview:
Shares one conv_engine between NUM_REQ row producers, for example multiple lane-detect controllers or camera row streams. Requests are granted round-robin. The block latches the winner's 32-pixel row, pulses the engine start, and waits for the engine's done, bounded by a watchdog. It then returns the 30-tap result tagged with the requester id. It sits between the per-stream controllers and the single conv_engine instance.

Parameters:
NUM_REQ, 2, number of requesters (legal 2..4)
TIMEOUT, 64, max cycles to wait for eng_done before aborting (legal >= 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset (0 = reset)
req_valid  in  NUM_REQ  per-requester row available
req_pixels  in  NUM_REQ*256  requester i row at [i*256 +: 256], pixel j at [j*8 +: 8]
req_ready  out  NUM_REQ  one-hot accept; a transfer occurs when req_valid[i] & req_ready[i]
eng_start  out  1  one-cycle start pulse to conv_engine
eng_pixels  out  256  latched row to conv_engine
eng_done  in  1  conv_engine completion pulse
eng_result  in  540  30 signed 18-bit taps, tap k at [k*18 +: 18]
resp_valid  out  1  one-cycle result pulse
resp_id  out  $clog2(NUM_REQ)  requester the result belongs to
resp_err  out  1  1 = watchdog abort, resp_data is zero
resp_data  out  540  captured eng_result
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst==0 at clk edge): state=IDLE, rr_ptr=0, timer=0. eng_start, resp_valid, resp_err, resp_id, resp_data and eng_pixels all go to 0. Reset mid-operation abandons the job with no response. A later eng_done from the engine is ignored.
- req_ready is combinational. It is nonzero only in IDLE, and has exactly one bit set: the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ. All other outputs are registered.
- IDLE: on a transfer, latch req_pixels of the granted index into eng_pixels and store grant, then go to ISSUE. With no req_valid, stay in IDLE.
- ISSUE: eng_start=1 for exactly this one cycle. Clear timer, then go to WAIT. eng_pixels stays stable from ISSUE through RESPOND.
- WAIT:
  - eng_done=1: capture eng_result into resp_data, resp_err<=0, go to RESPOND.
  - Otherwise, if timer==TIMEOUT-1: resp_data<=0, resp_err<=1, go to RESPOND.
  - Otherwise timer<=timer+1.
  - If eng_done and timeout coincide, eng_done wins.
- RESPOND: resp_valid=1 for one cycle, resp_id=grant, rr_ptr<=(grant+1) mod NUM_REQ, then go to IDLE. resp_data, resp_id and resp_err hold their values until the next RESPOND.
- eng_done in IDLE, ISSUE or RESPOND is ignored.
- Timing: handshake in cycle 0, eng_start in cycle 1, WAIT from cycle 2. If eng_done is seen in cycle d, resp_valid is in cycle d+1. Minimum accept-to-response is 3 cycles. Back-to-back throughput is one job per (engine latency + 3) cycles.
- A requester dropping req_valid before it is granted loses no state and is not served.
- Width rules: timer is $clog2(TIMEOUT) bits. rr_ptr and grant are $clog2(NUM_REQ) bits, with wrap by explicit compare to NUM_REQ-1 (NUM_REQ need not be a power of two).

Decomposition:
- Shared package npu_pkg holds:
  - PIXEL_W=8, ROW_PIXELS=32, ROW_W=256
  - RESULT_W=18, RESULT_LEN=30, RESULT_BUS_W=540
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESPOND}
- One sub-module, rr_pick: a combinational round-robin priority picker with inputs req[NUM_REQ] and ptr, and outputs one-hot gnt plus index. It is reusable by other shared-resource arbiters.

Test Plan:
1. NUM_REQ=2. Only req0 valid in cycle 0, with row pixel j = j. Engine model pulses done 5 cycles after start (cycle 6). Required: req_ready=01 in cycle 0; eng_start in cycle 1 with eng_pixels matching the row; resp_valid in cycle 7 with resp_id=0, resp_err=0 and resp_data equal to the model output.
2. Both requesters hold req_valid continuously after reset. Required: grants go 0, 1, 0, 1 with resp_id alternating. req_ready is never two-hot and never nonzero outside IDLE.
3. TIMEOUT=16 and the engine never asserts done, handshake in cycle 0. Required: resp_valid in cycle 18 with resp_err=1 and resp_data=0. An eng_done injected in cycle 20 produces no response and no state change.
4. Assert rst=0 in cycle 4, during WAIT. Required: in the next cycle busy=0, eng_start=0, resp_valid=0 and rr_ptr=0. A later eng_done pulse is ignored. A new req1 is served normally with resp_id=1.
5. eng_done and the timer's final count (timer=TIMEOUT-1) land in the same cycle. Required: resp_err=0 and resp_data equals eng_result.
6. NUM_REQ=3 with all three valid and rr_ptr=2 after a completed job. Required: grant order 2, 0, 1 and wrap-around with no index 3 ever produced.
